mandelbrot_pixel_sink: RTL
==========================

# mandelbrot_pixel_sink

Consumer end of the Mandelbrot engine's per-pixel run/running handshake. The block requests one pixel at a time from the engine and captures each 4-bit `ctr_out` result. It packs two pixels into each byte and emits the bytes on a valid/ready stream tagged with start-of-frame, end-of-line and end-of-frame flags. It sits between the engine and the output serializer/host interface, and it throttles the engine whenever the downstream side stalls.

## Interface
Parameters:
- `WIDTH`, 320: pixels per line; must be even.
- `HEIGHT`, 240: lines per frame.
- `FIFO_DEPTH`, 4: output byte FIFO entries; power of two, ≥2.

Ports:
- `clk`  in  1  the only clock; all logic on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `start`  in  1  level-sampled; in IDLE it begins one full frame.
- `busy`  out  1  high from frame accept until the EOF byte is handshaken.
- `frame_done`  out  1  one-cycle pulse on the EOF byte handshake.
- `eng_run`  out  1  drives engine `run`.
- `eng_running`  in  1  engine `running`.
- `eng_finished`  in  1  engine `finished`.
- `eng_ctr`  in  4  engine `ctr_out`.
- `out_data`  out  8  packed pixels: bits [3:0] = even x, bits [7:4] = odd x.
- `out_sof` / `out_eol` / `out_eof`  out  1 each  flags qualifying the current `out_data`.
- `out_valid`  out  1  byte available.
- `out_ready`  in  1  downstream accepts the byte when it is high together with `out_valid`.
- `frame_error`  out  1  sticky position-check error (see Configuration).

## Operation
- States:
  - IDLE: `start`=1 → REQ; x, y and the nibble register clear; `busy`=1.
  - REQ: if fifo_count < FIFO_DEPTH, assert `eng_run` for exactly one cycle → WAIT_START; otherwise hold in REQ with `eng_run`=0.
  - WAIT_START: wait for `eng_running`=1 → WAIT_DONE.
  - WAIT_DONE: the first cycle with `eng_running`=0 captures `eng_ctr` → CAPTURE.
  - CAPTURE: process the captured pixel.
    - Even x: store the nibble.
    - Odd x: push {flags, eng_ctr, stored nibble} into the FIFO.
    - Advance x/y.
    - Then → REQ, or → DRAIN after the pixel at (WIDTH-1, HEIGHT-1).
  - DRAIN: wait for the FIFO to empty → IDLE.
- Flag rules:
  - `out_sof` only on the byte holding (0,0).
  - `out_eol` on the byte holding x = WIDTH-1.
  - `out_eof` on the byte holding (WIDTH-1, HEIGHT-1); that byte also carries `out_eol`.
- Flow control:
  - A run is issued only when the FIFO has a free slot, so a push never overflows.
  - A push never arrives while the FIFO is full.
  - Push and pop in the same cycle leave the count unchanged.
- `start` while `busy` is ignored.
- x counter width is clog2(WIDTH); y counter width is clog2(HEIGHT). Both wrap x→0 / y+1 exactly as the engine scans.

## Timing
- Reset values: `busy`=0, `frame_done`=0, `eng_run`=0, `out_valid`=0, `out_data`=0, all flags 0, `frame_error`=0, state IDLE, FIFO empty.
- Cycle sequence:
  - `start` sampled at edge t → REQ at t+1.
  - `eng_run` high during cycle t+1 when space is available.
  - Engine `running` rises one cycle after it samples `run`.
- Capture latency: `eng_ctr` is sampled in the same cycle `eng_running` is first seen low. The engine updates `ctr_out` on the same edge that drops `running`.
- FIFO output is registered.
- A byte pushed at edge e has `out_valid`=1 from e+1 when the FIFO was empty.
- `out_data` and flags are held stable while `out_valid`=1 and `out_ready`=0.
- `frame_done` pulses in the cycle after the EOF handshake edge; `busy` falls in that same cycle.
- `rst` mid-frame: everything returns to the reset values next cycle and FIFO contents are discarded. The engine must be reset alongside the sink, since the engine keeps its own scan position.
- `eng_run` is never asserted outside REQ; minimum spacing between run pulses is 3 cycles.

## Configuration
- `MANDELBROT_SINK_CHECK_EN` defined: position check is active.
  - In CAPTURE, `eng_finished`=1 seen with (x,y) ≠ (WIDTH-1, HEIGHT-1) sets `frame_error`.
  - At the final pixel, `eng_finished`=0 also sets `frame_error`.
  - `frame_error` is sticky until `rst` or the next accepted `start`.
- Undefined: `frame_error` is tied to 0 and `eng_finished` is unused.

## Structure
- Package `mandelbrot_sink_pkg` holds:
  - the state enum (IDLE, REQ, WAIT_START, WAIT_DONE, CAPTURE, DRAIN);
  - the FIFO entry layout constants (data 8 bits, flag bit positions SOF=8, EOL=9, EOF=10; entry width 11).
- Sub-module `mandelbrot_byte_fifo`: synchronous FIFO with registered output, parameterized by depth and entry width, exposing count.

## Test plan
Bench uses a behavioural engine model with `WIDTH`=4, `HEIGHT`=2 unless noted; the model returns ctr = pixel index.
- `start` pulse, `out_ready`=1 → bytes 0x10, 0x32, 0x54, 0x76.
  - Flags: SOF on byte 0; EOL on bytes 1 and 3; EOF on byte 3.
  - `frame_done` pulses once and `busy` falls.
- `out_ready`=0 throughout, `FIFO_DEPTH`=2 → exactly 4 run pulses, then `eng_run` stays 0.
  - `out_data`=0x10 is held stable.
  - Raising `out_ready` resumes the run pulses.
- `start` asserted again mid-frame → ignored; output is still exactly 4 bytes.
- `rst` asserted in WAIT_DONE at pixel 5 → next cycle all outputs are at reset values and the FIFO is empty.
  - A new `start` then restarts with an SOF byte of 0x10.
- With `MANDELBROT_SINK_CHECK_EN`, the model asserts `finished` after pixel 2 → `frame_error`=1 and stays high until the next `start`.
  - Without the macro, `frame_error` stays 0.

Source files
------------

// File: rtl/mandelbrot_sink_pkg.sv
// mandelbrot_sink_pkg
// Shared definitions for the Mandelbrot pixel sink: the sink FSM state
// encoding and the bit layout of one output FIFO entry
// ({eof, eol, sof, odd nibble, even nibble}).
package mandelbrot_sink_pkg;

    typedef enum logic [2:0] {
        IDLE,
        REQ,
        WAIT_START,
        WAIT_DONE,
        CAPTURE,
        DRAIN
    } sink_state_t;

    localparam int DATA_W  = 8;
    localparam int SOF_BIT = 8;
    localparam int EOL_BIT = 9;
    localparam int EOF_BIT = 10;
    localparam int ENTRY_W = 11;

endpackage

// File: rtl/mandelbrot_byte_fifo.sv
// mandelbrot_byte_fifo
// Synchronous FIFO whose head entry sits in a register, so the consumer sees
// flop outputs that hold steady while it stalls.
// Ports:
//   clk, rst        clock, synchronous active-high reset (discards contents)
//   push, push_data write one entry (ignored when full)
//   pop             remove the head entry (ignored when empty)
//   head            registered head entry
//   head_valid      FIFO holds at least one entry
//   count           number of entries held (0..DEPTH)
module mandelbrot_byte_fifo #(
    parameter int DEPTH   = 4,
    parameter int ENTRY_W = 11
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  logic [ENTRY_W-1:0]         push_data,
    input  logic                       pop,
    output logic [ENTRY_W-1:0]         head,
    output logic                       head_valid,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [ENTRY_W-1:0] mem [DEPTH];
    logic [AW-1:0]      wr_ptr;
    logic [AW-1:0]      rd_ptr;
    logic [AW-1:0]      rd_ptr_next;
    logic [CW-1:0]      count_next;
    logic               do_push;
    logic               do_pop;

    assign do_pop      = pop && (count != '0);
    assign do_push     = push && (count != CW'(DEPTH));
    assign rd_ptr_next = do_pop ? rd_ptr + AW'(1) : rd_ptr;
    assign head_valid  = (count != '0);

    always_comb begin
        count_next = count;
        unique case ({do_push, do_pop})
            2'b10:   count_next = count + CW'(1);
            2'b01:   count_next = count - CW'(1);
            default: count_next = count;
        endcase
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    // The head register is loaded with whatever will sit at the read pointer
    // after this edge. When that slot is the one being written right now, the
    // array still holds stale data, so the incoming entry is forwarded.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            head   <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            rd_ptr <= rd_ptr_next;
            count  <= count_next;
            if (count_next != '0) begin
                head <= (do_push && (wr_ptr == rd_ptr_next)) ? push_data
                                                             : mem[rd_ptr_next];
            end
        end
    end

endmodule

// File: rtl/mandelbrot_pixel_sink.sv
// mandelbrot_pixel_sink
// Pulls one pixel at a time from the Mandelbrot engine over its run/running
// handshake, packs pixel pairs into bytes (even x in [3:0], odd x in [7:4])
// and streams them out with start-of-frame / end-of-line / end-of-frame flags.
// A run is only issued while the output FIFO has a free slot, so a stalled
// downstream throttles the engine.
// Optional feature macro: MANDELBROT_SINK_CHECK_EN enables the sticky
// frame_error check of the engine's finished flag against the scan position.
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   start               level; begins one frame when idle
//   busy, frame_done    frame in progress / one-cycle end-of-frame pulse
//   eng_run             engine run request
//   eng_running         engine running status
//   eng_finished        engine finished flag (checked only with the macro)
//   eng_ctr             engine iteration count for the current pixel
//   out_data            packed pixel pair
//   out_sof/eol/eof     flags qualifying out_data
//   out_valid/out_ready output stream handshake
//   frame_error         sticky position-check error
module mandelbrot_pixel_sink
    import mandelbrot_sink_pkg::*;
#(
    parameter int WIDTH      = 320,
    parameter int HEIGHT     = 240,
    parameter int FIFO_DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    output logic        busy,
    output logic        frame_done,
    output logic        eng_run,
    input  logic        eng_running,
    input  logic        eng_finished,
    input  logic [3:0]  eng_ctr,
    output logic [7:0]  out_data,
    output logic        out_sof,
    output logic        out_eol,
    output logic        out_eof,
    output logic        out_valid,
    input  logic        out_ready,
    output logic        frame_error
);

    localparam int XW = (WIDTH  > 1) ? $clog2(WIDTH)  : 1;
    localparam int YW = (HEIGHT > 1) ? $clog2(HEIGHT) : 1;
    localparam int CW = $clog2(FIFO_DEPTH) + 1;
    localparam logic [XW-1:0] X_LAST = XW'(WIDTH - 1);
    localparam logic [YW-1:0] Y_LAST = YW'(HEIGHT - 1);

    sink_state_t        state;
    sink_state_t        state_next;
    logic [XW-1:0]      x;
    logic [YW-1:0]      y;
    logic [3:0]         nibble;
    logic [3:0]         ctr_q;
    logic               at_last_x;
    logic               at_last;
    logic               push;
    logic [ENTRY_W-1:0] push_entry;
    logic [ENTRY_W-1:0] head;
    logic               head_valid;
    logic [CW-1:0]      fifo_count;
    logic               fifo_full;
    logic               pop;
    logic               eof_pop;

    assign at_last_x = (x == X_LAST);
    assign at_last   = at_last_x && (y == Y_LAST);
    assign fifo_full = (fifo_count == CW'(FIFO_DEPTH));
    assign pop       = head_valid && out_ready;
    assign eof_pop   = pop && head[EOF_BIT];

    // The byte is pushed when its odd pixel is captured, so the SOF byte is
    // the one completed at (1,0) and EOL/EOF follow the odd pixel's position.
    always_comb begin
        push_entry                 = '0;
        push_entry[3:0]            = nibble;
        push_entry[7:4]            = ctr_q;
        push_entry[SOF_BIT]        = (x == XW'(1)) && (y == '0);
        push_entry[EOL_BIT]        = at_last_x;
        push_entry[EOF_BIT]        = at_last;
    end

    always_comb begin
        state_next = state;
        eng_run    = 1'b0;
        push       = 1'b0;
        unique case (state)
            IDLE: begin
                if (start) state_next = REQ;
            end
            REQ: begin
                if (!fifo_full) begin
                    eng_run    = 1'b1;
                    state_next = WAIT_START;
                end
            end
            WAIT_START: begin
                if (eng_running) state_next = WAIT_DONE;
            end
            WAIT_DONE: begin
                if (!eng_running) state_next = CAPTURE;
            end
            CAPTURE: begin
                push       = x[0];
                state_next = at_last ? DRAIN : REQ;
            end
            // Leaving on the EOF handshake itself lets busy drop in the same
            // cycle that frame_done pulses.
            DRAIN: begin
                if (eof_pop) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            x          <= '0;
            y          <= '0;
            nibble     <= '0;
            ctr_q      <= '0;
            frame_done <= 1'b0;
        end else begin
            state      <= state_next;
            frame_done <= (state == DRAIN) && eof_pop;
            unique case (state)
                IDLE: begin
                    if (start) begin
                        x      <= '0;
                        y      <= '0;
                        nibble <= '0;
                    end
                end
                WAIT_DONE: begin
                    if (!eng_running) ctr_q <= eng_ctr;
                end
                CAPTURE: begin
                    if (!x[0]) nibble <= ctr_q;
                    if (at_last_x) begin
                        x <= '0;
                        y <= at_last ? '0 : y + YW'(1);
                    end else begin
                        x <= x + XW'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    mandelbrot_byte_fifo #(
        .DEPTH   (FIFO_DEPTH),
        .ENTRY_W (ENTRY_W)
    ) u_fifo (
        .clk        (clk),
        .rst        (rst),
        .push       (push),
        .push_data  (push_entry),
        .pop        (pop),
        .head       (head),
        .head_valid (head_valid),
        .count      (fifo_count)
    );

    assign busy      = (state != IDLE);
    assign out_valid = head_valid;
    assign out_data  = head[DATA_W-1:0];
    assign out_sof   = head[SOF_BIT];
    assign out_eol   = head[EOL_BIT];
    assign out_eof   = head[EOF_BIT];

`ifdef MANDELBROT_SINK_CHECK_EN
    logic frame_error_q;

    // The engine's finished flag must be high exactly on the last pixel.
    always_ff @(posedge clk) begin
        if (rst) begin
            frame_error_q <= 1'b0;
        end else if ((state == IDLE) && start) begin
            frame_error_q <= 1'b0;
        end else if ((state == CAPTURE) && (eng_finished != at_last)) begin
            frame_error_q <= 1'b1;
        end
    end

    assign frame_error = frame_error_q;
`else
    logic unused_eng_finished;
    assign unused_eng_finished = eng_finished;
    assign frame_error         = 1'b0;
`endif

endmodule
